// File: rtl/param_dpram_pkg.sv
// Shared state type and address-width helper for param_dual_port_ram.
package param_dpram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/param_dpram_clr_ctrl.sv
// Clear-sweep controller: walks sweep_ptr 0..DEPTH-1 (one word per cycle) while busy,
// then idles in READY until clr_req or rst restarts the sweep from address 0.
module param_dpram_clr_ctrl
  import param_dpram_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic [AW-1:0] sweep_ptr,
  output logic          sweep_we
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_q;
  logic [AW-1:0] sweep_ptr_q;
  logic          busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      sweep_ptr_q <= '0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          // Last word is written on this edge; user ports are live next cycle.
          if (sweep_ptr_q == LAST_ADDR) begin
            state_q     <= READY;
            sweep_ptr_q <= '0;
            busy_q      <= 1'b0;
          end else begin
            sweep_ptr_q <= sweep_ptr_q + AW'(1);
          end
        end
        READY: begin
          if (clr_req) begin
            state_q     <= CLEAR;
            sweep_ptr_q <= '0;
            busy_q      <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign sweep_we  = busy_q;
  assign sweep_ptr = sweep_ptr_q;

endmodule

// File: rtl/param_dual_port_ram.sv
// 1R1W RAM with self-clearing sweep; reads return one cycle after rd_en, user ports ignored while busy.
// PARAM_DPRAM_BYPASS_EN selects write-first same-address forwarding; default is read-first.
module param_dual_port_ram
  import param_dpram_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_req,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy
);

`ifdef PARAM_DPRAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // One extra bit so the range compare is meaningful for any DEPTH.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    sweep_ptr;
  logic             sweep_we;
  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_d;
  logic             rd_valid_q;

  param_dpram_clr_ctrl #(
    .DEPTH(DEPTH)
  ) u_clr_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .sweep_ptr(sweep_ptr),
    .sweep_we (sweep_we)
  );

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;
  assign wr_ok       = !rst && !busy && wr_en && wr_in_range;
  assign rd_ok       = !rst && !busy && rd_en;

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[sweep_ptr] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_q[rd_addr];
    end
    if (BYPASS && wr_ok && (wr_addr == rd_addr)) begin
      rd_word = wr_data;
    end
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (rd_ok) begin
      rd_data_d  = rd_word;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_param_dual_port_ram.sv
// Bench for param_dual_port_ram: a DEPTH=16 and a DEPTH=10 instance checked against an array model.
module tb_param_dual_port_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_clr_req, a_wr_en, a_rd_en, a_rd_valid, a_busy;
  logic [3:0] a_wr_addr, a_rd_addr;
  logic [7:0] a_wr_data, a_rd_data;
  logic       b_clr_req, b_wr_en, b_rd_en, b_rd_valid, b_busy;
  logic [3:0] b_wr_addr, b_rd_addr;
  logic [7:0] b_wr_data, b_rd_data;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [7:0] mdl [16];
  logic [7:0] last_rd;

`ifdef PARAM_DPRAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  param_dual_port_ram #(.WIDTH(8), .DEPTH(16)) dut_a (
    .clk(clk), .rst(rst), .clr_req(a_clr_req),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .busy(a_busy)
  );

  param_dual_port_ram #(.WIDTH(8), .DEPTH(10)) dut_b (
    .clk(clk), .rst(rst), .clr_req(b_clr_req),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_clr_req = 0; a_wr_en = 0; a_rd_en = 0; a_wr_addr = 0; a_rd_addr = 0; a_wr_data = 0;
    b_clr_req = 0; b_wr_en = 0; b_rd_en = 0; b_wr_addr = 0; b_rd_addr = 0; b_wr_data = 0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    idle_all();
    tick();
    tick();
    chk_cnt++;
    if (a_busy !== 1'b1 || a_rd_valid !== 1'b0 || a_rd_data !== 8'h00)
      $display("FAIL reset_state: busy=%b rd_valid=%b rd_data=%h, want 1 0 00", a_busy, a_rd_valid, a_rd_data);
    else pass_cnt++;
    chk_cnt++;
    if (b_busy !== 1'b1 || b_rd_valid !== 1'b0)
      $display("FAIL reset_state_d10: busy=%b rd_valid=%b, want 1 0", b_busy, b_rd_valid);
    else pass_cnt++;
    rst = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk_cnt++;
    if (n != 16) $display("FAIL reset_sweep_len: busy cycles=%0d, want 16", n);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      a_rd_en = 1'b1;
      a_rd_addr = 4'(i);
      tick();
      chk_cnt++;
      if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h00)
        $display("FAIL reset_zero[%0d]: rd_valid=%b rd_data=%h, want 1 00", i, a_rd_valid, a_rd_data);
      else pass_cnt++;
    end
    a_rd_en = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    last_rd = 8'h00;
  endtask

  task automatic test_write_read();
    a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 8'hA5;
    tick();
    mdl[3] = 8'hA5;
    a_wr_en = 1'b0;
    a_rd_en = 1'b1; a_rd_addr = 4'd3;
    tick();
    chk_cnt++;
    if (a_rd_valid !== 1'b1 || a_rd_data !== 8'hA5)
      $display("FAIL wr_rd: rd_valid=%b rd_data=%h, want 1 a5", a_rd_valid, a_rd_data);
    else pass_cnt++;
    a_rd_en = 1'b0; a_rd_addr = 4'd7;
    tick();
    chk_cnt++;
    if (a_rd_valid !== 1'b0 || a_rd_data !== 8'hA5)
      $display("FAIL rd_hold: rd_valid=%b rd_data=%h, want 0 a5", a_rd_valid, a_rd_data);
    else pass_cnt++;
    last_rd = 8'hA5;
  endtask

  task automatic test_read_during_write();
    logic [7:0] exp;
    a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 8'h11;
    tick();
    mdl[5] = 8'h11;
    a_wr_data = 8'h22;
    a_rd_en = 1'b1; a_rd_addr = 4'd5;
    exp = BYPASS ? 8'h22 : mdl[5];
    tick();
    mdl[5] = 8'h22;
    chk_cnt++;
    if (a_rd_valid !== 1'b1 || a_rd_data !== exp)
      $display("FAIL rdw_same_addr: rd_valid=%b rd_data=%h, want 1 %h", a_rd_valid, a_rd_data, exp);
    else pass_cnt++;
    a_wr_en = 1'b0;
    tick();
    chk_cnt++;
    if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h22)
      $display("FAIL rdw_later_read: rd_valid=%b rd_data=%h, want 1 22", a_rd_valid, a_rd_data);
    else pass_cnt++;
    a_rd_en = 1'b0;
    last_rd = 8'h22;
  endtask

  task automatic test_random_traffic();
    logic       we, re;
    logic [3:0] wa, ra;
    logic [7:0] wd, exp;
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      wd = 8'($urandom_range(0, 255));
      if (i % 4 == 0) ra = wa;
      a_wr_en = we; a_wr_addr = wa; a_wr_data = wd;
      a_rd_en = re; a_rd_addr = ra;
      exp = last_rd;
      if (re) exp = (BYPASS && we && wa == ra) ? wd : mdl[ra];
      if (we) mdl[wa] = wd;
      tick();
      chk_cnt++;
      if (a_rd_valid !== re || a_rd_data !== exp)
        $display("FAIL random[%0d]: rd_valid=%b rd_data=%h, want %b %h", i, a_rd_valid, a_rd_data, re, exp);
      else pass_cnt++;
      last_rd = exp;
    end
    idle_all();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    a_wr_en = 1'b1; a_wr_addr = 4'd15; a_wr_data = 8'hEE;
    tick();
    a_wr_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (7) tick();
    chk_cnt++;
    if (a_busy !== 1'b1) $display("FAIL mid_sweep_busy: busy=%b, want 1", a_busy);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    chk_cnt++;
    if (a_busy !== 1'b1 || a_rd_valid !== 1'b0 || a_rd_data !== 8'h00)
      $display("FAIL mid_sweep_rst: busy=%b rd_valid=%b rd_data=%h, want 1 0 00", a_busy, a_rd_valid, a_rd_data);
    else pass_cnt++;
    rst = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk_cnt++;
    if (n != 16) $display("FAIL mid_sweep_restart_len: busy cycles=%0d, want 16", n);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      a_rd_en = 1'b1; a_rd_addr = 4'(i);
      tick();
      chk_cnt++;
      if (a_rd_valid !== 1'b1 || a_rd_data !== mdl[i])
        $display("FAIL mid_sweep_zero[%0d]: rd_valid=%b rd_data=%h, want 1 %h", i, a_rd_valid, a_rd_data, mdl[i]);
      else pass_cnt++;
    end
    a_rd_en = 1'b0;
    last_rd = 8'h00;
  endtask

  task automatic test_clr_req();
    int n;
    logic [3:0] addrs [3];
    addrs[0] = 4'd9; addrs[1] = 4'd2; addrs[2] = 4'd4;
    a_wr_en = 1'b1; a_wr_addr = 4'd4; a_wr_data = 8'h77;
    tick();
    mdl[4] = 8'h77;
    a_clr_req = 1'b1;
    a_wr_addr = 4'd9; a_wr_data = 8'h3C;
    a_rd_en = 1'b1; a_rd_addr = 4'd4;
    tick();
    chk_cnt++;
    if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h77 || a_busy !== 1'b1)
      $display("FAIL clr_same_cycle: rd_valid=%b rd_data=%h busy=%b, want 1 77 1", a_rd_valid, a_rd_data, a_busy);
    else pass_cnt++;
    n = 0;
    while (a_busy === 1'b1 && n < 100) begin
      n++;
      a_clr_req = (n <= 3);
      a_wr_en = 1'b1; a_wr_addr = 4'd2; a_wr_data = 8'h5A;
      a_rd_en = 1'b1; a_rd_addr = 4'd4;
      tick();
      chk_cnt++;
      if (a_rd_valid !== 1'b0 || a_rd_data !== 8'h77)
        $display("FAIL clr_busy_ignore[%0d]: rd_valid=%b rd_data=%h, want 0 77", n, a_rd_valid, a_rd_data);
      else pass_cnt++;
    end
    idle_all();
    chk_cnt++;
    if (n != 16) $display("FAIL clr_sweep_len: busy cycles=%0d, want 16", n);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      a_rd_en = 1'b1; a_rd_addr = addrs[k];
      tick();
      chk_cnt++;
      if (a_rd_valid !== 1'b1 || a_rd_data !== mdl[addrs[k]])
        $display("FAIL clr_after[%0d]: rd_valid=%b rd_data=%h, want 1 %h", addrs[k], a_rd_valid, a_rd_data, mdl[addrs[k]]);
      else pass_cnt++;
    end
    a_rd_en = 1'b0;
  endtask

  task automatic test_depth10();
    int n;
    logic [3:0] oob [3];
    oob[0] = 4'd12; oob[1] = 4'd10; oob[2] = 4'd15;
    n = 0;
    while (b_busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk_cnt++;
    if (b_busy !== 1'b0) $display("FAIL d10_ready: busy=%b, want 0", b_busy);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      b_wr_en = 1'b1; b_wr_addr = 4'(i); b_wr_data = 8'(8'h30 + i);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      b_wr_en = 1'b1; b_wr_addr = oob[k]; b_wr_data = 8'hFF;
      tick();
    end
    b_wr_en = 1'b0;
    b_rd_en = 1'b1; b_rd_addr = 4'd12;
    tick();
    chk_cnt++;
    if (b_rd_valid !== 1'b1 || b_rd_data !== 8'h00)
      $display("FAIL d10_oob_read: rd_valid=%b rd_data=%h, want 1 00", b_rd_valid, b_rd_data);
    else pass_cnt++;
    b_wr_en = 1'b1; b_wr_addr = 4'd12; b_wr_data = 8'hFF;
    tick();
    b_wr_en = 1'b0;
    chk_cnt++;
    if (b_rd_valid !== 1'b1 || b_rd_data !== 8'h00)
      $display("FAIL d10_oob_rdw: rd_valid=%b rd_data=%h, want 1 00", b_rd_valid, b_rd_data);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      b_rd_addr = 4'(i);
      tick();
      chk_cnt++;
      if (b_rd_valid !== 1'b1 || b_rd_data !== 8'(8'h30 + i))
        $display("FAIL d10_keep[%0d]: rd_valid=%b rd_data=%h, want 1 %h", i, b_rd_valid, b_rd_data, 8'(8'h30 + i));
      else pass_cnt++;
    end
    b_rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_write_read();
    test_read_during_write();
    test_random_traffic();
    test_reset_mid_sweep();
    test_clr_req();
    test_depth10();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", pass_cnt, chk_cnt);
    $fatal(1, "timeout");
  end

endmodule
